// File: rtl/instr_encode_loader_pkg.sv
// Shared encoding constants, mnemonic codes and field-packing helpers for the instruction loader.
package instr_encode_loader_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_ADDIU = 6'h09;
  localparam logic [5:0] OPCODE_SLTI  = 6'h0A;
  localparam logic [5:0] OPCODE_SLTIU = 6'h0B;
  localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
  localparam logic [5:0] OPCODE_ORI   = 6'h0D;
  localparam logic [5:0] OPCODE_XORI  = 6'h0E;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  // Codes 21..31 are not assigned and are treated as illegal.
  typedef enum logic [4:0] {
    MN_ADD   = 5'd0,
    MN_ADDU  = 5'd1,
    MN_SUB   = 5'd2,
    MN_SUBU  = 5'd3,
    MN_AND   = 5'd4,
    MN_OR    = 5'd5,
    MN_XOR   = 5'd6,
    MN_SLL   = 5'd7,
    MN_SRA   = 5'd8,
    MN_SRL   = 5'd9,
    MN_SLT   = 5'd10,
    MN_SLTU  = 5'd11,
    MN_ADDI  = 5'd12,
    MN_ADDIU = 5'd13,
    MN_ANDI  = 5'd14,
    MN_ORI   = 5'd15,
    MN_XORI  = 5'd16,
    MN_SLTI  = 5'd17,
    MN_SLTIU = 5'd18,
    MN_BEQ   = 5'd19,
    MN_NOP   = 5'd20
  } mnem_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OPCODE_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] opcode, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opcode, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encode_loader_fifo.sv
// Synchronous FIFO holding encoded instruction words; pointers carry one wrap bit.
module instr_fifo
  #(parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32)
  (input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[PW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes symbolic instructions into MIPS words and streams them into instruction memory.
module instr_encode_loader
  import instr_encode_loader_pkg::*;
  #(parameter int unsigned        ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
    parameter int unsigned        FIFO_DEPTH = 2)
  (input  logic              CLK,
   input  logic              Reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_mnem,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic              in_last,
   output logic              imem_we,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [15:0]       instr_count,
   output logic              done,
   output logic              err_illegal,
   output logic              err_wrap);

  localparam int unsigned       FPW       = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   ADDR_STEP = (ADDR_W + 1)'(4);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_wrap_q, err_wrap_d;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept, push, wr_fire;
  logic              fifo_full, fifo_empty;
  logic [FPW:0]      fifo_count;
  logic [ADDR_W:0]   addr_inc;

  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    case (in_mnem)
      MN_ADD:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FUNCT_ADD);
      MN_ADDU:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FUNCT_ADDU);
      MN_SUB:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FUNCT_SUB);
      MN_SUBU:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FUNCT_SUBU);
      MN_AND:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FUNCT_AND);
      MN_OR:    enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FUNCT_OR);
      MN_XOR:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FUNCT_XOR);
      MN_SLT:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FUNCT_SLT);
      MN_SLTU:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FUNCT_SLTU);
      // Shifts take the shift amount from the immediate and never use rs.
      MN_SLL:   enc_word = pack_r(5'd0, in_rt, in_rd, in_imm[4:0], FUNCT_SLL);
      MN_SRL:   enc_word = pack_r(5'd0, in_rt, in_rd, in_imm[4:0], FUNCT_SRL);
      MN_SRA:   enc_word = pack_r(5'd0, in_rt, in_rd, in_imm[4:0], FUNCT_SRA);
      MN_ADDI:  enc_word = pack_i(OPCODE_ADDI, in_rs, in_rt, in_imm);
      MN_ADDIU: enc_word = pack_i(OPCODE_ADDIU, in_rs, in_rt, in_imm);
      MN_ANDI:  enc_word = pack_i(OPCODE_ANDI, in_rs, in_rt, in_imm);
      MN_ORI:   enc_word = pack_i(OPCODE_ORI, in_rs, in_rt, in_imm);
      MN_XORI:  enc_word = pack_i(OPCODE_XORI, in_rs, in_rt, in_imm);
      MN_SLTI:  enc_word = pack_i(OPCODE_SLTI, in_rs, in_rt, in_imm);
      MN_SLTIU: enc_word = pack_i(OPCODE_SLTIU, in_rs, in_rt, in_imm);
      MN_BEQ:   enc_word = pack_i(OPCODE_BEQ, in_rs, in_rt, in_imm);
      MN_NOP:   enc_word = '0;
      default:  enc_legal = 1'b0;
    endcase
  end

  assign in_ready = (state_q == ST_RUN) && !fifo_full;
  assign imem_we  = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !fifo_empty;
  assign accept   = in_valid && in_ready;
  assign push     = accept && enc_legal;
  assign wr_fire  = imem_we && imem_ready;
  assign addr_inc = {1'b0, addr_q} + ADDR_STEP;

  instr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (CLK),
    .rst   (Reset),
    .push  (push),
    .pop   (wr_fire),
    .wdata (enc_word),
    .rdata (imem_wdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    count_d       = count_q;
    err_illegal_d = err_illegal_q;
    err_wrap_d    = err_wrap_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_RUN;
          addr_d        = BASE_ADDR;
          count_d       = '0;
          err_illegal_d = 1'b0;
          err_wrap_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept && in_last) state_d = ST_DRAIN;
      end
      // Leave DRAIN as the last word is accepted so done follows the final write directly.
      ST_DRAIN: begin
        if (fifo_empty || (wr_fire && (fifo_count == (FPW + 1)'(1)))) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept && !enc_legal) err_illegal_d = 1'b1;
    if (wr_fire) begin
      addr_d = addr_inc[ADDR_W-1:0];
      if (addr_inc[ADDR_W]) err_wrap_d = 1'b1;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= BASE_ADDR;
      count_q       <= '0;
      err_illegal_q <= 1'b0;
      err_wrap_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      err_illegal_q <= err_illegal_d;
      err_wrap_q    <= err_wrap_d;
    end
  end

  assign imem_addr   = addr_q;
  assign instr_count = count_q;
  assign done        = (state_q == ST_DONE);
  assign err_illegal = err_illegal_q;
  assign err_wrap    = err_wrap_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed and randomized checks of the loader against a table-driven MIPS encoding model.
module tb_instr_encode_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, in_last, imem_ready;
  logic [4:0]  in_mnem, in_rs, in_rt, in_rd;
  logic [15:0] in_imm;

  logic        a_ready, a_we, a_done, a_eill, a_ewrap;
  logic [31:0] a_addr, a_wdata;
  logic [15:0] a_cnt;
  logic        b_ready, b_we, b_done, b_eill, b_ewrap;
  logic [3:0]  b_addr;
  logic [31:0] b_wdata;
  logic [15:0] b_cnt;

  instr_encode_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .FIFO_DEPTH(2)) dut_a (
    .CLK(clk), .Reset(rst), .start(start), .in_valid(in_valid), .in_ready(a_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(a_we), .imem_ready(imem_ready), .imem_addr(a_addr),
    .imem_wdata(a_wdata), .instr_count(a_cnt), .done(a_done), .err_illegal(a_eill),
    .err_wrap(a_ewrap));

  instr_encode_loader #(.ADDR_W(4), .BASE_ADDR(4'hC), .FIFO_DEPTH(2)) dut_b (
    .CLK(clk), .Reset(rst), .start(start), .in_valid(in_valid), .in_ready(b_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(b_we), .imem_ready(imem_ready), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .instr_count(b_cnt), .done(b_done), .err_illegal(b_eill),
    .err_wrap(b_ewrap));

  int n_checks = 0;
  int n_fail   = 0;

  // kind: 0 register op, 1 shift, 2 immediate op, 3 nop; val is funct or opcode
  localparam int KIND [21] = '{0,0,0,0,0,0,0, 1,1,1, 0,0, 2,2,2,2,2,2,2,2, 3};
  localparam int VAL  [21] = '{32,33,34,35,36,37,38, 0,3,2, 42,43, 8,9,12,13,14,10,11,4, 0};

  logic [31:0] exp_q[$];
  int          a_idx = 0, b_idx = 0, n_legal = 0;
  bit          saw_illegal = 0;
  int          hold_low = 0;
  bit          rand_mode = 0, rnd_start = 0;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_encode(input int m, input int rs, input int rt, input int rd,
                                    input int imm, output logic [31:0] w);
    int unsigned x;
    w = '0;
    if (m > 20) return 1'b0;
    case (KIND[m])
      0: x = rs * (2**21) + rt * (2**16) + rd * (2**11) + VAL[m];
      1: x = rt * (2**16) + rd * (2**11) + (imm % 32) * 64 + VAL[m];
      2: x = VAL[m] * (2**26) + rs * (2**21) + rt * (2**16) + imm;
      default: x = 0;
    endcase
    w = x;
    return 1'b1;
  endfunction

  task automatic check_write(input string nm, input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] exp_addr, inout int idx);
    if (we === 1'b1 && imem_ready === 1'b1) begin
      n_checks++;
      assert (idx < exp_q.size()) else begin
        n_fail++;
        $error("FAIL %s_extra_write: observed write number %0d expected only %0d", nm, idx + 1, exp_q.size());
      end
      if (idx < exp_q.size()) begin
        chk({nm, "_wdata"}, data, exp_q[idx]);
        chk({nm, "_addr"}, addr, exp_addr);
      end
      idx++;
    end
  endtask

  // Write monitor: scoreboard comparison plus hold-under-backpressure property.
  bit          prev_rst = 1, pa_stall = 0, pb_stall = 0;
  logic [31:0] pa_addr, pa_data, pb_data;
  logic [3:0]  pb_addr;
  always @(negedge clk) begin
    if (!rst) begin
      check_write("a", a_we, a_addr, a_wdata, 32'(4 * a_idx), a_idx);
      check_write("b", b_we, {28'h0, b_addr}, b_wdata, 32'((12 + 4 * b_idx) % 16), b_idx);
      if (!prev_rst && pa_stall) begin
        chk("a_hold_we", a_we, 1);
        chk("a_hold_addr", a_addr, pa_addr);
        chk("a_hold_data", a_wdata, pa_data);
      end
      if (!prev_rst && pb_stall) begin
        chk("b_hold_we", b_we, 1);
        chk("b_hold_addr", b_addr, pb_addr);
        chk("b_hold_data", b_wdata, pb_data);
      end
    end
    pa_stall = a_we && !imem_ready; pa_addr = a_addr; pa_data = a_wdata;
    pb_stall = b_we && !imem_ready; pb_addr = b_addr; pb_data = b_wdata;
    prev_rst = rst;
  end

  initial begin
    imem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (hold_low > 0) begin
        imem_ready = 1'b0;
        hold_low--;
      end else if (rand_mode) imem_ready = ($urandom_range(0, 3) != 0);
      else imem_ready = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic rand_fields();
    in_mnem = 5'($urandom); in_rs = 5'($urandom); in_rt = 5'($urandom);
    in_rd = 5'($urandom); in_imm = 16'($urandom);
    start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic do_start(input int hold);
    exp_q.delete(); a_idx = 0; b_idx = 0; n_legal = 0; saw_illegal = 0;
    start = 1'b1;
    hold_low = hold;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input int m, input int rs, input int rt, input int rd,
                           input int imm, input bit last, input int gap);
    bit acc;
    logic [31:0] w;
    repeat (gap) begin
      in_valid = 1'b0; in_last = 1'b0; rand_fields();
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_mnem = 5'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_last = last;
    start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
    acc = 1'b0;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      acc = (a_ready === 1'b1);
      @(posedge clk); #1;
    end
    n_checks++;
    assert (acc) else begin
      n_fail++;
      $error("FAIL accept_timeout: in_ready observed low for 200 cycles, expected a handshake");
    end
    if (acc) begin
      if (ref_encode(m, rs, rt, rd, imm, w)) begin
        exp_q.push_back(w);
        n_legal++;
      end else saw_illegal = 1'b1;
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
  endtask

  task automatic finish_session(input int exp_lat);
    int cyc = 0;
    start = 1'b0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (a_done === 1'b1) break;
    end
    chk("a_done_seen", a_done, 1);
    if (exp_lat > 0) chk("done_latency", cyc, exp_lat);
    chk("b_done", b_done, 1);
    chk("a_instr_count", a_cnt, (n_legal > 65535) ? 65535 : n_legal);
    chk("b_instr_count", b_cnt, (n_legal > 65535) ? 65535 : n_legal);
    chk("a_err_illegal", a_eill, saw_illegal);
    chk("b_err_illegal", b_eill, saw_illegal);
    chk("a_err_wrap", a_ewrap, (longint'(4) * n_legal >= 64'h1_0000_0000) ? 1 : 0);
    chk("b_err_wrap", b_ewrap, (12 + 4 * n_legal >= 16) ? 1 : 0);
    chk("a_writes", a_idx, exp_q.size());
    chk("b_writes", b_idx, exp_q.size());
    @(negedge clk);
    chk("a_done_pulse", a_done, 0);
    chk("b_done_pulse", b_done, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state();
    chk("rst_a_we", a_we, 0);         chk("rst_b_we", b_we, 0);
    chk("rst_a_in_ready", a_ready, 0); chk("rst_b_in_ready", b_ready, 0);
    chk("rst_a_addr", a_addr, 0);     chk("rst_b_addr", b_addr, 4'hC);
    chk("rst_a_wdata", a_wdata, 0);   chk("rst_b_wdata", b_wdata, 0);
    chk("rst_a_count", a_cnt, 0);     chk("rst_b_count", b_cnt, 0);
    chk("rst_a_done", a_done, 0);     chk("rst_a_eill", a_eill, 0);
    chk("rst_a_ewrap", a_ewrap, 0);   chk("rst_b_ewrap", b_ewrap, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;

    // Single ADD
    do_start(0);
    send_beat(0, 1, 2, 3, 0, 1'b1, 0);
    @(negedge clk);
    chk("t1_we", a_we, 1);
    chk("t1_wdata", a_wdata, 32'h00221820);
    chk("t1_addr", a_addr, 0);
    chk("t1_b_addr", b_addr, 4'hC);
    finish_session(1);

    // Back-to-back ADDI, SLL, BEQ
    do_start(0);
    send_beat(12, 0, 5, 0, 16'h0007, 1'b0, 0);
    send_beat(7, 9, 2, 4, 3, 1'b0, 0);
    send_beat(19, 1, 2, 0, 16'hFFFF, 1'b1, 0);
    @(negedge clk);
    chk("t2_wdata", a_wdata, 32'h1022FFFF);
    chk("t2_addr", a_addr, 32'h8);
    finish_session(1);

    // Backpressure: FIFO fills while imem_ready is held low
    do_start(4);
    send_beat(0, 3, 4, 5, 0, 1'b0, 0);
    send_beat(2, 6, 7, 8, 0, 1'b0, 0);
    @(negedge clk);
    chk("t3_full_in_ready", a_ready, 0);
    chk("t3_full_we", a_we, 1);
    @(posedge clk); #1;
    send_beat(6, 10, 11, 12, 0, 1'b1, 0);
    finish_session(-1);

    // Illegal mnemonic in the middle
    do_start(0);
    send_beat(0, 1, 1, 1, 0, 1'b0, 0);
    send_beat(25, 2, 2, 2, 16'h1234, 1'b0, 0);
    send_beat(15, 3, 4, 0, 16'hBEEF, 1'b1, 0);
    finish_session(2);

    // Reset while two words are stuck in the FIFO
    do_start(100);
    send_beat(13, 1, 2, 0, 16'h0042, 1'b0, 0);
    send_beat(16, 3, 4, 0, 16'h00FF, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hold_low = 0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    do_start(0);
    send_beat(1, 7, 8, 9, 0, 1'b1, 0);
    finish_session(2);

    // Randomized sessions with random backpressure, gaps and stray start pulses
    rand_mode = 1'b1;
    rnd_start = 1'b1;
    for (int s = 0; s < 4; s++) begin
      do_start(0);
      for (int b = 0; b < 25; b++) begin
        send_beat($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 65535), b == 24, $urandom_range(0, 2));
      end
      finish_session(-1);
    end
    rand_mode = 1'b0;
    rnd_start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Sequential instruction encoder/loader: the encode-side counterpart of the main/ALU control decoders.
- Accepts symbolic instructions (mnemonic plus register/immediate fields) over a valid/ready stream and packs them into 32-bit MIPS words, using the same opcode/funct values the decoders consume.
- Writes the words sequentially into instruction memory through a backpressured write port.
- Used by testbenches and boot logic to load programs before the single-cycle processor runs.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- BASE_ADDR, 0, byte address of the first instruction written after start.
- FIFO_DEPTH, 2, encoded-word buffer entries (power of 2, at least 2).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load session; honoured only in IDLE.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_mnem  in  5  mnemonic enum (package).
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate; bits [4:0] are shamt for shifts.
- in_last  in  1  final instruction of the session.
- imem_we  out  1  write request, held until accepted.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  ADDR_W  byte address of the write.
- imem_wdata  out  32  encoded instruction.
- instr_count  out  16  words written this session.
- done  out  1  one-cycle pulse at session end.
- err_illegal  out  1  sticky: an unknown mnemonic was dropped.
- err_wrap  out  1  sticky: the address wrapped past 2^ADDR_W.

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; imem_addr = BASE_ADDR. A reset in mid-session flushes the FIFO and abandons any pending write; imem_we is low the next cycle.
- State IDLE: in_ready=0. On start, go to RUN; clear instr_count, err_illegal and err_wrap; set addr = BASE_ADDR.
- State RUN: in_ready = !fifo_full. A beat is accepted when in_valid && in_ready. An accepted beat with in_last=1 moves to DRAIN.
- State DRAIN: in_ready=0. When the FIFO is empty and no write is pending, go to DONE.
- State DONE: done=1 for one cycle, then IDLE. start is ignored outside IDLE.
- Encoding is combinational at the FIFO input; the FIFO stores the 32-bit words.
  - R-type (add, addu, sub, subu, and, or, xor, slt, sltu): {6'b000000, rs, rt, rd, 5'b0, funct}.
  - Shifts (sll, srl, sra): {6'b0, 5'b0, rt, rd, imm[4:0], funct}; in_rs is ignored.
  - I-type (addi, addiu, andi, ori, xori, slti, sltiu, beq): {opcode, rs, rt, imm}.
  - NOP mnemonic: 32'h00000000 is written.
- Illegal mnemonic: the beat is accepted but not pushed; err_illegal is set; instr_count is unchanged. in_last on an illegal beat still moves to DRAIN.
- Write port: imem_we = FIFO non-empty (RUN or DRAIN). imem_wdata is the FIFO head.
  - On imem_we && imem_ready: pop the FIFO, addr += 4 modulo 2^ADDR_W, instr_count += 1 (saturating at 16'hFFFF).
  - An addr increment that crosses back to 0 sets err_wrap; writing continues.
  - imem_addr and imem_wdata are stable while imem_we=1 && imem_ready=0.
- Latency: a beat accepted in cycle N into an empty FIFO drives imem_we in cycle N+1. Throughput is 1 word/cycle with imem_ready tied high.
- Push and pop in the same cycle are allowed when the FIFO is not full. There is no bypass when full: in_ready is low when full, even if a pop occurs that cycle.

Decomposition:
- Shared package/header holds:
  - OPCODE_* and FUNCT_* constants, identical to the ones the control decoders use.
  - The 5-bit mnemonic enum: ADD, ADDU, SUB, SUBU, AND, OR, XOR, SLL, SRA, SRL, SLT, SLTU, ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, BEQ, NOP; codes 21-31 are illegal.
- Sub-module instr_fifo: synchronous FIFO with parameterised depth, push/pop/full/empty flags, clear on Reset.
- The encoder and the FSM stay in the top-level module.

Test Plan:
- start; ADD rs=1 rt=2 rd=3 with last=1; imem_ready=1 -> single write addr 0x0, data 0x00221820; done pulses 2 cycles after the accept; instr_count=1.
- Stream ADDI rt=5 rs=0 imm=0x0007, SLL rd=4 rt=2 imm=3, BEQ rs=1 rt=2 imm=0xFFFF (last) back-to-back -> data 0x20050007, 0x000220C0, 0x1022FFFF at addrs 0x0, 0x4, 0x8; one write per cycle.
- imem_ready low for 3 cycles during a stream -> imem_we held with addr/data unchanged; in_ready drops after FIFO_DEPTH accepts; no beat is lost or duplicated.
- Mnemonic code 25 in the middle of 3 beats -> err_illegal=1; only 2 writes at 0x0 and 0x4; instr_count=2.
- ADDR_W=4, BASE_ADDR=0xC, 2 instructions -> writes at 0xC then 0x0; err_wrap=1.
- Reset asserted while the FIFO holds 2 words and imem_ready=0 -> next cycle imem_we=0, in_ready=0, outputs at reset values; a following start writes from BASE_ADDR again.
